// File: rtl/video_line_reader_if.sv
// Handshake and data bundle between the line reader, its RAM and the video sinks.
// master = reader side, slave = capture/RAM/encoder side.
interface video_line_reader_if #(
  parameter int ADDR_BITS  = 18,
  parameter int DATA_WIDTH = 24
);
  logic                  starttrigger;
  logic                  add_line;
  logic                  h_double;
  logic                  v_double;
  logic [DATA_WIDTH-1:0] rddata;
  logic [ADDR_BITS-1:0]  rdaddr;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic                  frame_start;
  logic                  running;

  modport master (
    input  starttrigger, add_line, h_double, v_double, rddata,
    output rdaddr, pixel, hsync, vsync, de, frame_start, running
  );

  modport slave (
    output starttrigger, add_line, h_double, v_double, rddata,
    input  rdaddr, pixel, hsync, vsync, de, frame_start, running
  );
endinterface

// File: rtl/video_line_reader.sv
// Line-buffer RAM reader with full raster timing and optional pixel doubling.
// Define VIDEO_LINE_READER_SCANLINES_EN to dim the second line of each v-doubled pair.
module video_line_reader #(
  parameter int H_VISIBLE    = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_WIDTH = 96,
  parameter bit H_SYNC_POL   = 1'b0,
  parameter int V_VISIBLE    = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_TOTAL_ALT  = 526,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_WIDTH = 2,
  parameter bit V_SYNC_POL   = 1'b0,
  parameter int X_OFFSET     = 0,
  parameter int Y_OFFSET     = 0,
  parameter int LINE_LENGTH  = 640,
  parameter int NUM_WORDS    = 245760,
  parameter int ADDR_BITS    = 18,
  parameter int DATA_WIDTH   = 24,
  parameter int RAM_LATENCY  = 2
) (
  input  logic clock,
  input  logic reset,
  video_line_reader_if.master bus
);

  typedef logic [11:0] cnt_t;

  // Counter stages in front of the output register; the output
  // register itself provides the last cycle of RAM latency.
  localparam int PD = (RAM_LATENCY > 1) ? RAM_LATENCY - 1 : 1;

  localparam cnt_t HT_M1  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t VT_M1  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t VTA_M1 = cnt_t'(V_TOTAL_ALT - 1);
  localparam cnt_t HV     = cnt_t'(H_VISIBLE);
  localparam cnt_t VV     = cnt_t'(V_VISIBLE);
  localparam cnt_t XO     = cnt_t'(X_OFFSET);
  localparam cnt_t YO     = cnt_t'(Y_OFFSET);
  localparam cnt_t WX     = cnt_t'(H_VISIBLE - 2 * X_OFFSET);
  localparam cnt_t WY     = cnt_t'(V_VISIBLE - 2 * Y_OFFSET);
  localparam cnt_t HSS    = cnt_t'(H_SYNC_START);
  localparam cnt_t HSW    = cnt_t'(H_SYNC_WIDTH);
  localparam cnt_t VSS    = cnt_t'(V_SYNC_START);
  localparam cnt_t VSE    = cnt_t'(V_SYNC_START + V_SYNC_WIDTH);
  localparam cnt_t LL_M1  = cnt_t'(LINE_LENGTH - 1);

  localparam logic [ADDR_BITS:0] LL_W = (ADDR_BITS + 1)'(LINE_LENGTH);
  localparam logic [ADDR_BITS:0] NW_W = (ADDR_BITS + 1)'(NUM_WORDS);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    cnt_t x;
    cnt_t y;
    logic win;
    logic run;
  } tap_t;

  state_t               state_q, state_d;
  logic [2:0]           cfg_q, cfg;
  cnt_t                 x_q, x_d, y_q, y_d;
  cnt_t                 col_q, col_d;
  logic                 hph_q, hph_d;
  logic                 vph_q, vph_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS:0]   nb;
  tap_t                 pipe_q [PD];
  tap_t                 pipe_d [PD];
  tap_t                 cur, tap;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 de_q, de_d;
  logic                 fs_q, fs_d;
  logic                 gate_q, gate_d;
  logic                 run, change, win, x_end, y_end;
  logic                 vs_act;
  cnt_t                 vt_m1;
  logic [DATA_WIDTH-1:0] pix_src;

  function automatic logic in_y(input cnt_t y);
    return (y - YO) < WY;
  endfunction

  assign cfg    = {bus.add_line, bus.h_double, bus.v_double};
  assign change = cfg != cfg_q;
  assign run    = state_q == RUN;
  assign win    = ((x_q - XO) < WX) && in_y(y_q);
  assign vt_m1  = bus.add_line ? VTA_M1 : VT_M1;
  assign x_end  = x_q == HT_M1;
  assign y_end  = y_q == vt_m1;
  assign nb     = {1'b0, base_q} + LL_W;
  assign cur    = {x_q, y_q, win, run};
  assign tap    = (RAM_LATENCY > 1) ? pipe_q[PD-1] : cur;

  // Run/idle control, raster counters, column and line-base tracking.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    hph_d   = hph_q;
    vph_d   = vph_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: if (!change && bus.starttrigger) state_d = RUN;
      RUN:  if (change) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != RUN || state_d != RUN) begin
      x_d    = '0;
      y_d    = '0;
      col_d  = '0;
      hph_d  = 1'b0;
      vph_d  = 1'b0;
      base_d = '0;
    end else if (x_end) begin
      x_d   = '0;
      col_d = '0;
      hph_d = 1'b0;
      if (y_end) begin
        y_d    = '0;
        vph_d  = 1'b0;
        base_d = '0;
      end else begin
        y_d = y_q + 12'd1;
        if (in_y(y_q) && in_y(y_q + 12'd1)) begin
          if (bus.v_double && !vph_q) begin
            vph_d = 1'b1;
          end else begin
            vph_d  = 1'b0;
            base_d = (nb >= NW_W) ? '0 : nb[ADDR_BITS-1:0];
          end
        end
      end
    end else begin
      x_d = x_q + 12'd1;
      if (win) begin
        if (!bus.h_double || hph_q)
          col_d = (col_q == LL_M1) ? col_q : col_q + 12'd1;
        hph_d = bus.h_double ? ~hph_q : 1'b0;
      end
    end
  end

  // Counter delay line matching the RAM latency; cleared when idle.
  always_comb begin
    for (int i = 0; i < PD; i++) pipe_d[i] = '0;
    if (state_d == RUN) begin
      pipe_d[0] = cur;
      for (int i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // Sync, enable and pixel gate decoded from the delayed counters.
  always_comb begin
    vs_act  = ((tap.y == VSS) && (tap.x >= HSS))
           || ((tap.y > VSS) && (tap.y < VSE))
           || ((tap.y == VSE) && (tap.x < HSS));
    hsync_d = ~H_SYNC_POL;
    vsync_d = ~V_SYNC_POL;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    gate_d  = 1'b0;
    if (state_d == RUN && tap.run) begin
      if ((tap.x - HSS) < HSW) hsync_d = H_SYNC_POL;
      if (vs_act) vsync_d = V_SYNC_POL;
      de_d   = (tap.x < HV) && (tap.y < VV);
      fs_d   = (tap.x == '0) && (tap.y == '0);
      gate_d = tap.win;
    end
  end

  // State, counter, pipeline and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cfg_q   <= cfg;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      hph_q   <= 1'b0;
      vph_q   <= 1'b0;
      base_q  <= '0;
      for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      base_q  <= base_d;
      pipe_q  <= pipe_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      gate_q  <= gate_d;
    end
  end

`ifdef VIDEO_LINE_READER_SCANLINES_EN
  logic [PD-1:0]         vpipe_q, vpipe_d;
  logic                  vcur, vtap;
  logic                  scan_q, scan_d;
  logic [DATA_WIDTH-1:0] half_mask;

  assign vcur = run && bus.v_double && vph_q;
  assign vtap = (RAM_LATENCY > 1) ? vpipe_q[PD-1] : vcur;

  // Per-channel mask dropping the bit shifted in from the next channel.
  always_comb begin
    half_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) half_mask[i] = (i % 8) != 7;
  end

  // Second-line phase delayed alongside the counters.
  always_comb begin
    vpipe_d = '0;
    scan_d  = 1'b0;
    if (state_d == RUN) begin
      vpipe_d = (vpipe_q << 1) | PD'(vcur);
      scan_d  = tap.run && vtap;
    end
  end

  // Phase pipeline and scanline select registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vpipe_q <= '0;
      scan_q  <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      scan_q  <= scan_d;
    end
  end

  assign pix_src = scan_q ? ((bus.rddata >> 1) & half_mask) : bus.rddata;
`else
  assign pix_src = bus.rddata;
`endif

  assign bus.rdaddr      = (run && win) ? base_q + ADDR_BITS'(col_q) : '0;
  assign bus.pixel       = gate_q ? pix_src : '0;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.running     = run;

endmodule

// File: tb/tb_video_line_reader.sv
// Directed bench for video_line_reader on a 16x8 raster.
// Two instances differ only in line-buffer size to exercise the base wrap.
module tb_video_line_reader;

`ifdef VIDEO_LINE_READER_SCANLINES_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic fe_mode;
  logic [7:0] a_r1, a_r2, b_r1, b_r2;
  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  video_line_reader_if #(.ADDR_BITS(8), .DATA_WIDTH(24)) a_if ();
  video_line_reader_if #(.ADDR_BITS(8), .DATA_WIDTH(24)) b_if ();

  video_line_reader #(
    .H_VISIBLE(10), .H_TOTAL(16), .H_SYNC_START(12),
    .H_SYNC_WIDTH(2), .V_VISIBLE(5), .V_TOTAL(8),
    .V_TOTAL_ALT(9), .V_SYNC_START(6), .V_SYNC_WIDTH(1),
    .LINE_LENGTH(10), .NUM_WORDS(40), .ADDR_BITS(8),
    .DATA_WIDTH(24), .RAM_LATENCY(2)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus(a_if)
  );

  video_line_reader #(
    .H_VISIBLE(10), .H_TOTAL(16), .H_SYNC_START(12),
    .H_SYNC_WIDTH(2), .V_VISIBLE(5), .V_TOTAL(8),
    .V_TOTAL_ALT(9), .V_SYNC_START(6), .V_SYNC_WIDTH(1),
    .LINE_LENGTH(10), .NUM_WORDS(20), .ADDR_BITS(8),
    .DATA_WIDTH(24), .RAM_LATENCY(2)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus(b_if)
  );

  // Two-cycle RAM models returning data = address.
  always @(posedge clock) begin
    a_r1 <= a_if.rdaddr;
    a_r2 <= a_r1;
    b_r1 <= b_if.rdaddr;
    b_r2 <= b_r1;
  end

  assign a_if.rddata = fe_mode ? 24'hFEFEFE : {16'd0, a_r2};
  assign b_if.rddata = {16'd0, b_r2};

  function automatic logic [7:0] exp_addr(input int k, input bit dbl,
                                          input int nw);
    int x, y;
    x = k % 16;
    y = (k / 16) % 8;
    if (x >= 10 || y >= 5) return 8'd0;
    if (dbl) return 8'(((y / 2) * 10) % nw + x / 2);
    return 8'((y * 10) % nw + x);
  endfunction

  // {hsync, vsync, de, frame_start} seen k cycles after trigger.
  function automatic logic [3:0] exp_ctl(input int k);
    int x, y;
    logic hs, vs, de, fs;
    if (k < 2) return 4'b1100;
    x = (k - 2) % 16;
    y = ((k - 2) / 16) % 8;
    hs = !(x == 12 || x == 13);
    vs = !((y == 6 && x >= 12) || (y == 7 && x < 12));
    de = (x < 10) && (y < 5);
    fs = (x == 0) && (y == 0);
    return {hs, vs, de, fs};
  endfunction

  function automatic logic [23:0] exp_pix(input int k, input bit dbl,
                                          input int nw);
    if (k < 2) return 24'd0;
    return {16'd0, exp_addr(k - 2, dbl, nw)};
  endfunction

  task automatic test_reset();
    logic [4:0] sa, sb;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    sa = {a_if.running, a_if.hsync, a_if.vsync, a_if.de, a_if.frame_start};
    sb = {b_if.running, b_if.hsync, b_if.vsync, b_if.de, b_if.frame_start};
    checks++;
    if (sa !== 5'b01100)
      $display("FAIL reset_ctl_a got %b exp 01100", sa);
    else passes++;
    checks++;
    if (sb !== 5'b01100)
      $display("FAIL reset_ctl_b got %b exp 01100", sb);
    else passes++;
    checks++;
    if (a_if.rdaddr !== 8'd0 || a_if.pixel !== 24'd0)
      $display("FAIL reset_data got %h/%h exp 0/0",
               a_if.rdaddr, a_if.pixel);
    else passes++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_run();
    logic [3:0] ctl, prev;
    int vfall, vrise, nde, nfs;
    logic hfv, hfr;
    vfall = -1; vrise = -1; nde = 0; nfs = 0;
    hfv = 1'b0; hfr = 1'b0;
    prev = 4'b1100;
    a_if.starttrigger = 1'b1;
    @(negedge clock);
    a_if.starttrigger = 1'b0;
    for (int k = 0; k < 258; k++) begin
      ctl = {a_if.hsync, a_if.vsync, a_if.de, a_if.frame_start};
      checks++;
      if (a_if.rdaddr !== exp_addr(k, 1'b0, 40))
        $display("FAIL run_addr k=%0d got %0d exp %0d",
                 k, a_if.rdaddr, exp_addr(k, 1'b0, 40));
      else passes++;
      checks++;
      if (a_if.pixel !== exp_pix(k, 1'b0, 40))
        $display("FAIL run_pixel k=%0d got %h exp %h",
                 k, a_if.pixel, exp_pix(k, 1'b0, 40));
      else passes++;
      checks++;
      if (ctl !== exp_ctl(k))
        $display("FAIL run_ctl k=%0d got %b exp %b",
                 k, ctl, exp_ctl(k));
      else passes++;
      if (k >= 2 && k < 130 && ctl[1]) nde++;
      if (ctl[0]) nfs++;
      if (prev[2] && !ctl[2] && vfall < 0) begin
        vfall = k;
        hfv = prev[3] && !ctl[3];
      end
      if (!prev[2] && ctl[2] && vrise < 0) begin
        vrise = k;
        hfr = prev[3] && !ctl[3];
      end
      prev = ctl;
      @(negedge clock);
    end
    checks++;
    if (nde !== 50) $display("FAIL de_count got %0d exp 50", nde);
    else passes++;
    checks++;
    if (nfs !== 2) $display("FAIL fs_count got %0d exp 2", nfs);
    else passes++;
    checks++;
    if (vfall !== 110 || hfv !== 1'b1)
      $display("FAIL vsync_fall got k=%0d hs=%b exp k=110 hs=1",
               vfall, hfv);
    else passes++;
    checks++;
    if (vrise !== 126 || hfr !== 1'b1)
      $display("FAIL vsync_rise got k=%0d hs=%b exp k=126 hs=1",
               vrise, hfr);
    else passes++;
  endtask

  task automatic test_double();
    a_if.h_double = 1'b1;
    a_if.v_double = 1'b1;
    @(negedge clock);
    checks++;
    if (a_if.running !== 1'b0)
      $display("FAIL dbl_stop got %b exp 0", a_if.running);
    else passes++;
    @(negedge clock);
    a_if.starttrigger = 1'b1;
    @(negedge clock);
    a_if.starttrigger = 1'b0;
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (a_if.rdaddr !== exp_addr(k, 1'b1, 40))
        $display("FAIL dbl_addr k=%0d got %0d exp %0d",
                 k, a_if.rdaddr, exp_addr(k, 1'b1, 40));
      else passes++;
      checks++;
      if (a_if.pixel !== exp_pix(k, 1'b1, 40))
        $display("FAIL dbl_pixel k=%0d got %h exp %h",
                 k, a_if.pixel, exp_pix(k, 1'b1, 40));
      else passes++;
      @(negedge clock);
    end
    a_if.h_double = 1'b0;
    a_if.v_double = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_add_line();
    logic [3:0] ctl;
    int n;
    a_if.starttrigger = 1'b1;
    @(negedge clock);
    a_if.starttrigger = 1'b0;
    repeat (40) @(negedge clock);
    checks++;
    if (a_if.de !== 1'b1 || a_if.running !== 1'b1)
      $display("FAIL al_active got de=%b run=%b exp 1/1",
               a_if.de, a_if.running);
    else passes++;
    a_if.add_line = 1'b1;
    @(negedge clock);
    ctl = {a_if.hsync, a_if.vsync, a_if.de, a_if.frame_start};
    checks++;
    if (a_if.running !== 1'b0)
      $display("FAIL al_running got %b exp 0", a_if.running);
    else passes++;
    checks++;
    if (ctl !== 4'b1100)
      $display("FAIL al_ctl got %b exp 1100", ctl);
    else passes++;
    checks++;
    if (a_if.rdaddr !== 8'd0 || a_if.pixel !== 24'd0)
      $display("FAIL al_data got %h/%h exp 0/0",
               a_if.rdaddr, a_if.pixel);
    else passes++;
    @(negedge clock);
    a_if.starttrigger = 1'b1;
    @(negedge clock);
    a_if.starttrigger = 1'b0;
    n = 0;
    while (a_if.frame_start !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 300) $display("FAIL al_first_fs got timeout exp pulse");
    else passes++;
    @(negedge clock);
    n = 1;
    while (a_if.frame_start !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== 144) $display("FAIL al_period got %0d exp 144", n);
    else passes++;
    a_if.add_line = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_scanlines();
    int x, y;
    logic [23:0] ep;
    a_if.v_double = 1'b1;
    repeat (2) @(negedge clock);
    fe_mode = 1'b1;
    a_if.starttrigger = 1'b1;
    @(negedge clock);
    a_if.starttrigger = 1'b0;
    for (int k = 0; k < 82; k++) begin
      ep = 24'd0;
      if (k >= 2) begin
        x = (k - 2) % 16;
        y = (k - 2) / 16;
        if (x < 10 && y < 5)
          ep = (SCAN && y % 2 == 1) ? 24'h7F7F7F : 24'hFEFEFE;
      end
      checks++;
      if (a_if.pixel !== ep)
        $display("FAIL scan_pixel k=%0d got %h exp %h",
                 k, a_if.pixel, ep);
      else passes++;
      @(negedge clock);
    end
    a_if.v_double = 1'b0;
    repeat (2) @(negedge clock);
    fe_mode = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic [4:0] sb;
    b_if.starttrigger = 1'b1;
    @(negedge clock);
    b_if.starttrigger = 1'b0;
    for (int k = 0; k < 131; k++) begin
      checks++;
      if (b_if.rdaddr !== exp_addr(k, 1'b0, 20))
        $display("FAIL wrap_addr k=%0d got %0d exp %0d",
                 k, b_if.rdaddr, exp_addr(k, 1'b0, 20));
      else passes++;
      checks++;
      if (b_if.pixel !== exp_pix(k, 1'b0, 20))
        $display("FAIL wrap_pixel k=%0d got %h exp %h",
                 k, b_if.pixel, exp_pix(k, 1'b0, 20));
      else passes++;
      @(negedge clock);
    end
    checks++;
    if (b_if.de !== 1'b1)
      $display("FAIL mid_line_de got %b exp 1", b_if.de);
    else passes++;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb = {b_if.running, b_if.hsync, b_if.vsync, b_if.de, b_if.frame_start};
    checks++;
    if (sb !== 5'b01100)
      $display("FAIL mid_reset_ctl got %b exp 01100", sb);
    else passes++;
    checks++;
    if (b_if.rdaddr !== 8'd0 || b_if.pixel !== 24'd0)
      $display("FAIL mid_reset_data got %h/%h exp 0/0",
               b_if.rdaddr, b_if.pixel);
    else passes++;
    repeat (2) @(negedge clock);
    checks++;
    if (b_if.running !== 1'b0)
      $display("FAIL mid_reset_stay got %b exp 0", b_if.running);
    else passes++;
  endtask

  initial begin
    reset = 1'b0;
    fe_mode = 1'b0;
    a_if.starttrigger = 1'b0;
    a_if.add_line = 1'b0;
    a_if.h_double = 1'b0;
    a_if.v_double = 1'b0;
    b_if.starttrigger = 1'b0;
    b_if.add_line = 1'b0;
    b_if.h_double = 1'b0;
    b_if.v_double = 1'b0;
    test_reset();
    test_run();
    test_double();
    test_add_line();
    test_scanlines();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
